// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// Store path between the CPU store stage and a word-wide synchronous data RAM
// that has no byte enables. Word stores go straight to a memory write. Halfword
// and byte stores use a read-modify-write: read the word, replace the addressed
// lane with the payload, write the merged word back.
//
// Ports
//   clock       in   system clock, rising-edge active
//   reset       in   asynchronous, active-low reset
//   req         in   store request, sampled only while ready=1
//   addr        in   byte address of the store
//   wdata       in   store data, payload right-aligned
//   control     in   size code: 1,3 halfword; 2,4 byte; others word
//   ready       out  idle and able to accept req
//   done        out  one-cycle pulse in the memory write cycle
//   misaligned  out  one-cycle pulse when a request is rejected for alignment
//   mem_addr    out  memory word address (latched addr without the byte offset)
//   mem_read    out  memory read strobe (rdata valid the following cycle)
//   mem_rdata   in   memory read data
//   mem_write   out  memory write strobe
//   mem_wdata   out  memory write data
//
// All outputs come straight from registers. The strobes are loaded from the
// next-state value, so each one is high exactly for the cycle the FSM spends
// in the matching state. Only DATA_WIDTH=32 is supported.
// -----------------------------------------------------------------------------
module store_merge_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [2:0]            control,
    output logic                  ready,
    output logic                  done,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    // Size code decode; unlisted codes fall back to a full-word store.
    function automatic size_t decode_size(input logic [2:0] ctrl);
        size_t sz;
        case (ctrl)
            3'd1, 3'd3: sz = SZ_HALF;
            3'd2, 3'd4: sz = SZ_BYTE;
            default:    sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // A byte can never be misaligned; halfwords need an even address and
    // words need a multiple of four.
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = lo[0];
            SZ_BYTE: mis = 1'b0;
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

    // Little-endian lane replacement; bits outside the lane keep the read data.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] old_word,
        input logic [15:0] payload,
        input size_t       sz,
        input logic [1:0]  lo
    );
        logic [31:0] merged;
        merged = old_word;
        case (sz)
            SZ_BYTE: merged[{lo, 3'b000} +: 8] = payload[7:0];
            SZ_HALF: begin
                if (lo[1]) begin
                    merged[31:16] = payload;
                end else begin
                    merged[15:0] = payload;
                end
            end
            default: merged = old_word;
        endcase
        return merged;
    endfunction

    state_t                  state_r;
    state_t                  next_state_s;
    size_t                   req_size_s;
    logic                    req_mis_s;
    logic                    accept_s;

    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [15:0]             payload_r;
    size_t                   size_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;

    logic                    ready_r;
    logic                    done_r;
    logic                    misaligned_r;
    logic                    mem_read_r;
    logic                    mem_write_r;

    assign req_size_s = decode_size(control);
    assign req_mis_s  = is_misaligned(req_size_s, addr[1:0]);
    assign accept_s   = (state_r == ST_IDLE) && req;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; the IDLE branch classifies the incoming request.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    if (req_mis_s) begin
                        next_state_s = ST_ERR;
                    end else if (req_size_s == SZ_WORD) begin
                        next_state_s = ST_WRITE;
                    end else begin
                        next_state_s = ST_READ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ:  next_state_s = ST_MERGE;
            ST_MERGE: next_state_s = ST_WRITE;
            ST_WRITE: next_state_s = ST_IDLE;
            ST_ERR:   next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Request latch: captured once at acceptance so later input changes are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_r    <= '0;
            payload_r <= 16'h0000;
            size_r    <= SZ_WORD;
        end else if (accept_s) begin
            addr_r    <= addr;
            payload_r <= wdata[15:0];
            size_r    <= req_size_s;
        end else begin
            addr_r    <= addr_r;
            payload_r <= payload_r;
            size_r    <= size_r;
        end
    end

    // Write data: full word at acceptance of a word store, merged word at the
    // end of MERGE (mem_rdata is valid during MERGE, one cycle after READ).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_wdata_r <= 32'h0000_0000;
        end else if (accept_s && !req_mis_s && (req_size_s == SZ_WORD)) begin
            mem_wdata_r <= wdata;
        end else if (state_r == ST_MERGE) begin
            mem_wdata_r <= merge_lane(mem_rdata, payload_r, size_r, addr_r[1:0]);
        end else begin
            mem_wdata_r <= mem_wdata_r;
        end
    end

    // Registered strobes, loaded from the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_r      <= 1'b1;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
        end else begin
            ready_r      <= (next_state_s == ST_IDLE);
            done_r       <= (next_state_s == ST_WRITE);
            misaligned_r <= (next_state_s == ST_ERR);
            mem_read_r   <= (next_state_s == ST_READ);
            mem_write_r  <= (next_state_s == ST_WRITE);
        end
    end

    assign ready      = ready_r;
    assign done       = done_r;
    assign misaligned = misaligned_r;
    assign mem_read   = mem_read_r;
    assign mem_write  = mem_write_r;
    assign mem_addr   = addr_r[ADDR_WIDTH-1:2];
    assign mem_wdata  = mem_wdata_r;

endmodule
